// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receiver with a 2-flop input synchronizer, parity/frame checking
//   and a valid/ready output holding register with a sticky overrun flag.
// Latency: the byte appears on out (with out_valid) one cycle after the mid-stop-bit sample.
// Backpressure: out_valid holds until out_ready; a byte completing while the held byte is
//   not accepted is dropped and sets overrun.
// Ports:
//   clk, rst_n          - clock, async active-low reset
//   in                  - serial line (asynchronous, idle high)
//   out/out_valid/out_ready - received byte handshake
//   parity_err/frame_err    - per-byte flags, qualified by out_valid
//   overrun/err_clr     - sticky dropped-byte flag and its clear pulse
//   busy                - receiver not in IDLE
module uart_rx_ctrl #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_EN    = 1'b1,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in,
  output logic [7:0] out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  input  logic       err_clr,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_idx;
  logic [7:0]      r_shift;
  logic            r_perr;
  logic            r_sync1;
  logic            r_sync2;
  logic [7:0]      r_out;
  logic            r_out_valid;
  logic            r_parity_err;
  logic            r_frame_err;
  logic            r_overrun;

  logic w_rx_s;
  logic w_bit_end;
  logic w_half;
  logic w_complete;
  logic w_accept;

  assign w_rx_s     = r_sync2;
  assign w_bit_end  = (r_cnt == CNT_MAX);
  assign w_half     = (r_cnt == CNT_HALF);
  assign w_complete = (r_state == S_STOP) && w_bit_end;
  assign w_accept   = r_out_valid && out_ready;

  // Synchronizer flops reset to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= in;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_shift      <= '0;
      r_perr       <= 1'b0;
      r_out        <= 8'h00;
      r_out_valid  <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_cnt <= r_cnt + CW'(1);

      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (!w_rx_s) r_state <= S_START;
        end
        // Re-check the line mid start bit; a short low pulse is rejected here.
        S_START: begin
          if (w_half) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_perr  <= 1'b0;
            r_state <= w_rx_s ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_cnt          <= '0;
            r_shift[r_idx] <= w_rx_s;
            r_idx          <= r_idx + 3'd1;
            if (r_idx == 3'd7) r_state <= PARITY_EN ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_perr  <= (^r_shift) ^ w_rx_s ^ PARITY_ODD;
            r_state <= S_STOP;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_state <= w_rx_s ? S_IDLE : S_BREAK;
          end
        end
        // Line held low past the stop bit: wait for idle before looking for a start.
        S_BREAK: begin
          r_cnt <= '0;
          if (w_rx_s) r_state <= S_IDLE;
        end
        default: begin
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
      endcase

      // Output holding register: load when empty or being drained this cycle.
      if (w_complete && (!r_out_valid || out_ready)) begin
        r_out        <= r_shift;
        r_parity_err <= PARITY_EN ? r_perr : 1'b0;
        r_frame_err  <= ~w_rx_s;
        r_out_valid  <= 1'b1;
      end else if (w_accept) begin
        r_out_valid  <= 1'b0;
      end

      // A new overrun wins over a simultaneous clear.
      if (w_complete && r_out_valid && !out_ready) r_overrun <= 1'b1;
      else if (err_clr)                            r_overrun <= 1'b0;
    end
  end

  assign out        = r_out;
  assign out_valid  = r_out_valid;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: scoreboard bench for uart_rx_ctrl (16 clocks/bit, even parity).
// Frames are driven bit by bit; expected bytes are queued at drive time and popped on
// each out_valid && out_ready handshake.
module tb_uart_rx_ctrl;

  localparam int CPB = 16;

  logic       clk;
  logic       rst_n;
  logic       rx_line;
  logic [7:0] out;
  logic       out_valid;
  logic       out_ready;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       err_clr;
  logic       busy;

  uart_rx_ctrl #(
    .CLKS_PER_BIT(CPB),
    .PARITY_EN(1'b1),
    .PARITY_ODD(1'b0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in         (rx_line),
    .out        (out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .err_clr    (err_clr),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp   = 0;
  int   n_err   = 0;
  int   n_push  = 0;
  int   n_hs    = 0;
  int   n_extra = 0;
  int   n_vcyc  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) n_vcyc++;
      if (out_valid && out_ready) begin
        n_hs++;
        if (sb_q.size() == 0) begin
          n_extra++;
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("data", {24'd0, out}, {24'd0, e.d});
          check("parity_err", {31'd0, parity_err}, {31'd0, e.pe});
          check("frame_err", {31'd0, frame_err}, {31'd0, e.fe});
        end
      end
    end
  end

  task automatic hold(input logic v, input int n);
    rx_line = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives start, 8 data bits LSB first, parity, then stop for stop_cyc cycles.
  // Line is left at the stop level; caller returns it to idle.
  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic sbit,
                            input int stop_cyc, input bit push);
    exp_t e;
    if (push) begin
      e.d  = d;
      e.pe = (^d) ^ pbit;
      e.fe = ~sbit;
      sb_q.push_back(e);
      n_push++;
    end
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(d[i], CPB);
    hold(pbit, CPB);
    hold(sbit, stop_cyc);
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while (sb_q.size() != 0 && k < 400) begin
      @(posedge clk);
      k++;
    end
    #1;
    check(tag, sb_q.size(), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_out"}, {24'd0, out}, 32'h00);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_perr"}, {31'd0, parity_err}, 32'd0);
    check({tag, "_ferr"}, {31'd0, frame_err}, 32'd0);
    check({tag, "_ovr"}, {31'd0, overrun}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    int h0;
    logic [7:0] d;

    rx_line   = 1'b1;
    out_ready = 1'b1;
    err_clr   = 1'b0;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");
    rst_n = 1'b1;
    hold(1'b1, 10);

    // Good frame, parity correct; valid must be a single-cycle pulse with ready high.
    v0 = n_vcyc;
    send_frame(8'hA5, 1'b0, 1'b1, CPB, 1'b1);
    hold(1'b1, 2 * CPB);
    drain("drain_a5");
    check("a5_valid_cycles", n_vcyc - v0, 1);

    // Wrong parity bit.
    send_frame(8'hA5, 1'b1, 1'b1, CPB, 1'b1);
    hold(1'b1, 2 * CPB);
    drain("drain_a5_perr");

    // Stop bit low, line held low 40 cycles: frame error, break, no extra byte.
    h0 = n_hs;
    send_frame(8'h3C, 1'b0, 1'b0, 40, 1'b1);
    check("busy_in_break", {31'd0, busy}, 32'd1);
    hold(1'b1, 6);
    check("busy_after_break", {31'd0, busy}, 32'd0);
    hold(1'b1, 3 * CPB);
    drain("drain_3c");
    check("break_one_byte", n_hs - h0, 1);

    // Glitch of 4 cycles must be rejected.
    v0 = n_vcyc;
    hold(1'b0, 4);
    hold(1'b1, 3 * CPB);
    check("glitch_no_valid", n_vcyc - v0, 0);
    check("glitch_busy", {31'd0, busy}, 32'd0);
    send_frame(8'h12, 1'b0, 1'b1, CPB, 1'b1);
    hold(1'b1, 2 * CPB);
    drain("drain_12");

    // Overrun: hold the consumer off, second byte is dropped.
    out_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1, CPB, 1'b1);
    hold(1'b1, 2 * CPB);
    send_frame(8'h22, 1'b0, 1'b1, CPB, 1'b0);
    hold(1'b1, 2 * CPB);
    check("ovr_out_held", {24'd0, out}, 32'h11);
    check("ovr_valid", {31'd0, out_valid}, 32'd1);
    check("ovr_set", {31'd0, overrun}, 32'd1);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    check("ovr_clr", {31'd0, overrun}, 32'd0);
    out_ready = 1'b1;
    hold(1'b1, 4);
    drain("drain_11");

    // Reset in the middle of data bit 4 aborts the frame.
    d = 8'hC3;
    hold(1'b0, CPB);
    for (int i = 0; i < 4; i++) hold(d[i], CPB);
    hold(d[4], 8);
    check("busy_mid_frame", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    rx_line = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b1;
    hold(1'b1, 10);
    send_frame(8'h5A, 1'b0, 1'b1, CPB, 1'b1);
    hold(1'b1, 2 * CPB);
    drain("drain_5a");

    check("extra_bytes", n_extra, 0);
    check("handshakes", n_hs, n_push);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
